// File: rtl/serial_to_parallel.sv
// serial_to_parallel: assembles an LSB-first serial bit stream into DATA_W-bit words with valid/ready on both sides.
// Define SERIAL_TO_PARALLEL_PARITY_EN to add a trailing even-parity bit per frame and the p_err_o flag.
module serial_to_parallel #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid_i,
    input  logic              s_data_i,
    output logic              s_ready_o,
    output logic              p_valid_o,
    output logic [DATA_W-1:0] p_data_o,
    input  logic              p_ready_i
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    ,
    output logic              p_err_o
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    localparam int FRAME_LEN = DATA_W + 1;
`else
    localparam int FRAME_LEN = DATA_W;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              sr_full_q, sr_full_d;
    logic              p_valid_q, p_valid_d;
    logic [DATA_W-1:0] p_data_q, p_data_d;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    logic              sr_err_q, sr_err_d;
    logic              p_err_q, p_err_d;
    logic              frame_err;
`endif

    logic              bit_accept;
    logic              slot_free;
    logic              frame_last;
    logic [DATA_W-1:0] frame_word;

    assign s_ready_o  = ~sr_full_q;
    assign bit_accept = s_valid_i & ~sr_full_q;
    assign slot_free  = ~p_valid_q | p_ready_i;
    assign frame_last = (cnt_q == LAST_CNT);

    // With parity the data bits are all in sr already; the bit arriving now is the parity bit.
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    assign frame_word = sr_q;
    assign frame_err  = (^sr_q) ^ s_data_i;
`else
    assign frame_word = {s_data_i, sr_q[DATA_W-2:0]};
`endif

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        sr_full_d = sr_full_q;
        p_valid_d = p_valid_q;
        p_data_d  = p_data_q;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
        sr_err_d  = sr_err_q;
        p_err_d   = p_err_q;
`endif

        if (p_valid_q && p_ready_i) begin
            p_valid_d = 1'b0;
        end

        // Drain the collect register; cannot coincide with a final-bit accept since s_ready_o is low.
        if (sr_full_q && slot_free) begin
            p_data_d  = sr_q;
            p_valid_d = 1'b1;
            sr_full_d = 1'b0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            p_err_d   = sr_err_q;
`endif
        end

        if (bit_accept) begin
            if (frame_last) begin
                cnt_d = '0;
                if (slot_free) begin
                    p_data_d  = frame_word;
                    p_valid_d = 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                    p_err_d   = frame_err;
`endif
                end else begin
                    sr_d      = frame_word;
                    sr_full_d = 1'b1;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
                    sr_err_d  = frame_err;
`endif
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                for (int i = 0; i < DATA_W; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        sr_d[i] = s_data_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cnt_q     <= '0;
            sr_q      <= '0;
            sr_full_q <= 1'b0;
            p_valid_q <= 1'b0;
            p_data_q  <= '0;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            sr_err_q  <= 1'b0;
            p_err_q   <= 1'b0;
`endif
        end else begin
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            sr_full_q <= sr_full_d;
            p_valid_q <= p_valid_d;
            p_data_q  <= p_data_d;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
            sr_err_q  <= sr_err_d;
            p_err_q   <= p_err_d;
`endif
        end
    end

    assign p_valid_o = p_valid_q;
    assign p_data_o  = p_data_q;
`ifdef SERIAL_TO_PARALLEL_PARITY_EN
    assign p_err_o   = p_err_q;
`endif

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Downstream partner of the parallel-to-serial stage. Consumes an LSB-first serial bit stream under a valid/ready handshake and assembles DATA_W-bit words. Presents each word on a parallel valid/ready output port. A one-word collect register plus a one-word output register let the next word be gathered while the consumer stalls.

Parameters:
DATA_W, 4, width of the assembled parallel word (must be >= 2)

Ports:
clk  input  1  single clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
s_valid_i  input  1  serial bit valid
s_data_i  input  1  serial bit, LSB of the word first
s_ready_o  output  1  block can accept a serial bit this cycle
p_valid_o  output  1  assembled word valid
p_data_o  output  DATA_W  assembled word
p_ready_i  input  1  consumer accepts the word this cycle
p_err_o  output  1  parity error flag; exists only with SERIAL_TO_PARALLEL_PARITY_EN

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values:
  - s_ready_o=1, p_valid_o=0, p_data_o=0, p_err_o=0.
  - Bit counter cnt=0, collect register sr=0, sr_full=0.
- Bit accept: s_valid_i & s_ready_o. s_ready_o = ~sr_full (no combinational path from p_ready_i or s_valid_i).
- On accept with cnt=k (k < DATA_W-1): sr[k] <= s_data_i, cnt <= k+1. Bit k always lands in word bit k.
- On accept of the final bit (cnt=DATA_W-1), the word is {s_data_i, sr[DATA_W-2:0]}, and cnt <= 0.
  - If the output slot is free (~p_valid_o | p_ready_i): load it into p_data_o and set p_valid_o=1 next cycle.
  - Otherwise: store the word in sr and set sr_full=1.
- Drain of collect register: when sr_full & (~p_valid_o | p_ready_i), load p_data_o <= sr, keep p_valid_o=1, clear sr_full. s_ready_o returns to 1 in the following cycle.
- Output handshake:
  - Word transfers when p_valid_o & p_ready_i.
  - p_valid_o falls after a transfer unless a new word is loaded in the same cycle.
  - p_data_o must stay stable while p_valid_o=1 and p_ready_i=0.
- Latency: p_valid_o rises the cycle after the final bit is accepted, when the output slot is free.
- Throughput: one bit per cycle sustained with p_ready_i=1; no bubbles between consecutive words.
- Gaps: idle cycles (s_valid_i=0) between bits have no effect on cnt or sr.
- Full condition: sr_full=1 and p_valid_o=1 with p_ready_i=0. s_ready_o stays 0 until drain; serial bits offered meanwhile are not accepted and must be held by the producer.
- Simultaneous events:
  - Drain and final-bit accept cannot coincide, because s_ready_o=0 while sr_full=1.
  - Output transfer and a new load in the same cycle keeps p_valid_o=1 with the new data.
- Reset mid-word: the partial word is discarded and cnt=0. Any held or pending word is dropped.
- Counter width: $clog2(DATA_W+1) bits. Wraps to 0 after the final bit of each frame.

Optional Feature:
Macro SERIAL_TO_PARALLEL_PARITY_EN.
- Defined:
  - Each frame is DATA_W data bits followed by one even-parity bit, DATA_W+1 accepted bits in total.
  - The parity bit is consumed, not stored in p_data_o. Word completion and load rules apply at the parity bit instead of bit DATA_W-1.
  - p_err_o = XOR(data bits) ^ parity bit. It is loaded alongside p_data_o, valid while p_valid_o=1, and held in the collect path when sr_full.
- Undefined: frames are exactly DATA_W bits and the p_err_o port is absent.

Test Plan:
1. DATA_W=4, p_ready_i=1, bits 1,0,1,1 on consecutive cycles -> p_valid_o=1 for one cycle, the cycle after the 4th accept, with p_data_o=4'hD.
2. Continuous stream of words 4'hA then 4'h5, p_ready_i=1 -> s_ready_o constantly 1; p_valid_o pulses 4 cycles apart with 4'hA then 4'h5.
3. Backpressure, p_ready_i=0, send 4'h3 then 4'hC:
   - p_data_o holds 4'h3, sr_full=1, s_ready_o=0, and a third word stalls.
   - Raise p_ready_i: 4'h3 transfers, 4'hC appears the same edge, and s_ready_o returns to 1 one cycle later.
4. Word 4'h6 sent with random 0-3 idle cycles between bits -> p_data_o=4'h6, no extra or missing words.
5. Reset asserted after 2 bits of a word, then full word 4'h9 -> single output 4'h9; no output from the partial word.
6. With SERIAL_TO_PARALLEL_PARITY_EN, word 4'h7:
   - Parity bit 1 -> p_data_o=4'h7, p_err_o=0.
   - Parity bit 0 -> p_data_o=4'h7, p_err_o=1.
